rggen_bus_arbiter: RTL and testbench

RGGEN_BUS_ARBITER -- requirements
Module: rggen_bus_arbiter

---
 rtl/rggen_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter that funnels several register-access requesters onto a
// single downstream register bus, one transaction at a time.
//
// Handshake: a requester raises i_valid with its request fields and holds
// them until it sees its o_ready bit pulse for one cycle; that pulse carries
// o_status/o_read_data.  Downstream, o_m_valid and the o_m_* fields stay
// constant while BUSY, and the transaction completes in the first BUSY cycle
// with i_m_ready=1 (or is aborted with SLAVE_ERROR after TIMEOUT BUSY cycles
// when TIMEOUT is non-zero).
module rggen_bus_arbiter #(
    parameter int REQUESTERS    = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQUESTERS-1:0]               i_valid,
    input  logic [REQUESTERS-1:0]               i_write,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_write_data,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_strobe,
    output logic [REQUESTERS-1:0]               o_ready,
    output logic [1:0]                          o_status,
    output logic [DATA_WIDTH-1:0]               o_read_data,
    output logic                                o_m_valid,
    output logic                                o_m_write,
    output logic [ADDRESS_WIDTH-1:0]            o_m_address,
    output logic [DATA_WIDTH-1:0]               o_m_write_data,
    output logic [DATA_WIDTH-1:0]               o_m_strobe,
    input  logic                                i_m_ready,
    input  logic [1:0]                          i_m_status,
    input  logic [DATA_WIDTH-1:0]               i_m_read_data,
    output logic                                debug_state
);

    localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] COUNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [GW-1:0] GRANT_LAST = GW'(REQUESTERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pointer;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic [CW-1:0]   count;
    logic            timed_out;
    logic            complete;
    int              idx;

    assign debug_state = (state == BUSY);

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = int'(pointer) + k;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            if (!pick_valid && i_valid[idx]) begin
                pick       = GW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    // A downstream response always beats a coincident timeout.
    assign timed_out = (TIMEOUT > 0) && (state == BUSY) && !i_m_ready && (count == COUNT_LAST);
    assign complete  = (state == BUSY) && (i_m_ready || timed_out);

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = BUSY;
            BUSY:    if (complete)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response pulse to the granted requester; zero outside completion cycles.
    always_comb begin
        o_ready     = '0;
        o_status    = 2'd0;
        o_read_data = '0;
        if (complete) begin
            o_ready[grant] = 1'b1;
            if (i_m_ready) begin
                o_status    = i_m_status;
                o_read_data = i_m_read_data;
            end else begin
                o_status = 2'd2;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Downstream request registers, grant, pointer and BUSY cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_m_valid      <= 1'b0;
            o_m_write      <= 1'b0;
            o_m_address    <= '0;
            o_m_write_data <= '0;
            o_m_strobe     <= '0;
            grant          <= '0;
            pointer        <= '0;
            count          <= '0;
        end else if ((state == IDLE) && pick_valid) begin
            o_m_valid      <= 1'b1;
            o_m_write      <= i_write[pick];
            o_m_address    <= i_address[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            o_m_write_data <= i_write_data[pick*DATA_WIDTH +: DATA_WIDTH];
            o_m_strobe     <= i_strobe[pick*DATA_WIDTH +: DATA_WIDTH];
            grant          <= pick;
            count          <= '0;
        end else if (complete) begin
            o_m_valid <= 1'b0;
            pointer   <= (grant == GRANT_LAST) ? '0 : grant + 1'b1;
            count     <= '0;
        end else if ((state == BUSY) && (TIMEOUT > 0)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Randomized bench for rggen_bus_arbiter: requesters and a downstream
// responder are driven at random, a transaction-level model predicts grants
// and responses into queues, and a monitor compares what the DUT presents.
module tb_rggen_bus_arbiter;

    localparam int R   = 3;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TO  = 6;
    localparam int RQW = 1 + AW + 2 * DW;
    localparam int RSW = R + 2 + DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [R-1:0]    i_valid, i_write;
    logic [R*AW-1:0] i_address;
    logic [R*DW-1:0] i_write_data, i_strobe;
    logic [R-1:0]    o_ready;
    logic [1:0]      o_status;
    logic [DW-1:0]   o_read_data;
    logic            o_m_valid, o_m_write;
    logic [AW-1:0]   o_m_address;
    logic [DW-1:0]   o_m_write_data, o_m_strobe;
    logic            i_m_ready = 1'b0;
    logic [1:0]      i_m_status = 2'd0;
    logic [DW-1:0]   i_m_read_data = '0;
    logic            debug_state;

    rggen_bus_arbiter #(
        .REQUESTERS(R), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_write(i_write), .i_address(i_address),
        .i_write_data(i_write_data), .i_strobe(i_strobe),
        .o_ready(o_ready), .o_status(o_status), .o_read_data(o_read_data),
        .o_m_valid(o_m_valid), .o_m_write(o_m_write), .o_m_address(o_m_address),
        .o_m_write_data(o_m_write_data), .o_m_strobe(o_m_strobe),
        .i_m_ready(i_m_ready), .i_m_status(i_m_status), .i_m_read_data(i_m_read_data),
        .debug_state(debug_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int chk = 0;
    int err = 0;
    logic [RQW-1:0] req_q[$];
    int             req_t[$];
    logic [RSW-1:0] exp_q[$];
    int             exp_t[$];

    bit   m_busy = 0;
    int   m_ptr  = 0;
    int   m_g    = 0;
    int   m_cnt  = 0;
    bit   allow_new = 0;
    logic [R-1:0] rdy_seen = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: a grant goes to the first requesting port at or after
    // the pointer; a transaction ends on the first BUSY cycle the responder is
    // ready, or on BUSY cycle number TO with SLAVE_ERROR.
    always @(negedge clk) begin
        logic [R-1:0] oh;
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0;
            req_q.delete(); req_t.delete(); exp_q.delete(); exp_t.delete();
        end else if (m_busy) begin
            m_cnt++;
            oh = '0;
            oh[m_g] = 1'b1;
            if (i_m_ready) begin
                exp_q.push_back({oh, i_m_status, i_m_read_data});
                exp_t.push_back(cyc);
                m_busy = 0;
                m_ptr = (m_g + 1) % R;
            end else if (m_cnt == TO) begin
                exp_q.push_back({oh, 2'd2, {DW{1'b0}}});
                exp_t.push_back(cyc);
                m_busy = 0;
                m_ptr = (m_g + 1) % R;
            end
        end else if (|i_valid) begin
            for (int k = R - 1; k >= 0; k--) begin
                if (i_valid[(m_ptr + k) % R]) m_g = (m_ptr + k) % R;
            end
            req_q.push_back({i_write[m_g], i_address[m_g*AW +: AW],
                             i_write_data[m_g*DW +: DW], i_strobe[m_g*DW +: DW]});
            req_t.push_back(cyc + 1);
            m_busy = 1;
            m_cnt  = 0;
        end
    end

    // ---------------- monitor ----------------
    logic           prev_mv = 1'b0;
    logic [RQW-1:0] cur_req = '0;
    always @(negedge clk) begin
        logic [RQW-1:0] got_req;
        logic [RSW-1:0] e;
        #1;
        got_req = {o_m_write, o_m_address, o_m_write_data, o_m_strobe};
        if (!rst_n) begin
            check("reset_outputs", {o_m_valid, o_ready, o_status, o_read_data}, '0);
            prev_mv  = 1'b0;
            rdy_seen = '0;
        end else begin
            rdy_seen = o_ready;
            if (o_m_valid && !prev_mv) begin
                if (req_q.size() == 0) begin
                    check("unexpected_grant", o_m_valid, 1'b0);
                end else begin
                    check("grant_latency", req_t.pop_front(), cyc);
                    cur_req = req_q.pop_front();
                    check("grant_fields", got_req, cur_req);
                end
            end else if (o_m_valid) begin
                check("request_hold", got_req, cur_req);
            end
            while (req_t.size() > 0 && req_t[0] < cyc) begin
                check("grant_missing", req_t[0], cyc);
                void'(req_t.pop_front());
                void'(req_q.pop_front());
            end
            if (o_ready != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", o_ready, '0);
                end else begin
                    check("resp_cycle", exp_t.pop_front(), cyc);
                    e = exp_q.pop_front();
                    check("resp_value", {o_ready, o_status, o_read_data}, e);
                end
            end else begin
                check("idle_resp_zero", {o_status, o_read_data}, '0);
                if (exp_t.size() > 0 && exp_t[0] <= cyc) begin
                    e = exp_q.pop_front();
                    void'(exp_t.pop_front());
                    check("resp_missing", o_ready, e[RSW-1 -: R]);
                end
            end
            prev_mv = o_m_valid;
        end
    end

    // ---------------- requester driver ----------------
    task automatic new_fields(input int r);
        i_write[r]                = 1'($urandom);
        i_address[r*AW +: AW]     = AW'($urandom);
        i_write_data[r*DW +: DW]  = $urandom;
        i_strobe[r*DW +: DW]      = $urandom;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int r = 0; r < R; r++) begin
                if (i_valid[r] && rdy_seen[r]) begin
                    i_valid[r] = 1'b0;
                    if (allow_new && $urandom_range(0, 2) == 0) begin
                        i_valid[r] = 1'b1;
                        new_fields(r);
                    end
                end else if (!i_valid[r]) begin
                    if (allow_new && $urandom_range(0, 1) == 0) begin
                        i_valid[r] = 1'b1;
                        new_fields(r);
                    end
                end else if (!(m_busy && m_g == r) && $urandom_range(0, 1) == 0) begin
                    new_fields(r);
                end
            end
        end
    end

    // ---------------- downstream responder ----------------
    int rcnt = 0;
    int rdly = 0;
    always @(posedge clk) begin
        #1;
        i_m_status    = 2'($urandom);
        i_m_read_data = $urandom;
        if (!rst_n) begin
            i_m_ready = 1'b0;
            rcnt = 0;
        end else if (o_m_valid) begin
            if (rcnt == 0) rdly = $urandom_range(0, TO + 2);
            i_m_ready = (rcnt == rdly);
            rcnt++;
        end else begin
            rcnt = 0;
            i_m_ready = ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit found;
        i_valid = '0; i_write = '0; i_address = '0; i_write_data = '0; i_strobe = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_valid", o_m_valid, 1'b0);
        check("rst_m_fields", {o_m_write, o_m_address, o_m_write_data, o_m_strobe}, '0);
        check("rst_ready", o_ready, '0);
        check("rst_state", debug_state, 1'b0);

        @(posedge clk); #2;
        rst_n = 1'b1;
        allow_new = 1;
        repeat (1500) @(posedge clk);

        // Reset in the middle of a transaction.
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk); #2;
            if (o_m_valid) found = 1;
        end
        if (!found) check("busy_wait", o_m_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", o_m_valid, 1'b0);
        check("midrst_resp", {o_ready, o_status, o_read_data}, '0);
        check("midrst_state", debug_state, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        i_valid = '1;
        for (int r = 0; r < R; r++) new_fields(r);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("post_reset_valid", o_m_valid, 1'b1);
        check("post_reset_first", o_m_address, i_address[0 +: AW]);

        repeat (800) @(posedge clk);

        // Drain outstanding requests.
        allow_new = 0;
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk); #2;
            if (i_valid == '0 && !o_m_valid) found = 1;
        end
        check("drain", {i_valid, o_m_valid}, '0);
        repeat (3) @(posedge clk);
        check("req_q_empty", req_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
